rob_param: RTL and testbench

Parametrised reorder buffer for the out-of-order RISC-V core. It sits between the decoder/issue stage, the reservation station, the load/store buffer, the common data buses and the register file. It allocates entries in program order and accepts results from `NUM_CDB` result buses. It retires one entry per cycle in order and resolves branch mispredictions at commit with a flush and a corrected PC. Depth and the number of result buses are generic.

---
 rtl/rob_param_pkg.sv | 25 ++
 rtl/rob_param_if.sv | 57 +++++
 rtl/rob_cdb_merge.sv | 35 +++
 rtl/rob_param.sv | 192 +++++++++++++++++++
 tb/tb_rob_param.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_param_pkg.sv
// Shared types and helpers for the parametrised reorder buffer.
package rob_param_pkg;

    localparam int unsigned ROB_TAG_NONE = 32'd0;
    localparam int unsigned ROB_PC_INC   = 32'd4;

    function automatic int rob_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that tag 0 can mean "no producer" while tags run 1..DEPTH.
    function automatic int rob_tag_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic       valid;
        logic       ready;
        logic       is_branch;
        logic       is_store;
        logic [4:0] rd;
        logic       pred_taken;
    } rob_ctrl_t;

endpackage

// File: rtl/rob_param_if.sv
// Bundle of the decoder, operand lookup, result bus, commit and redirect signals of the ROB.
interface rob_param_if #(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32
);
    import rob_param_pkg::*;
    localparam int TAG_W = rob_tag_w(DEPTH);

    logic                    dec2rob_en;
    logic                    dec_is_branch;
    logic                    dec_is_store;
    logic [4:0]              dec_rd;
    logic [XLEN-1:0]         dec_pc;
    logic                    dec_pred_taken;
    logic [XLEN-1:0]         dec_target;
    logic [TAG_W-1:0]        newTag;
    logic                    robFull;
    logic                    robEmpty;
    logic [TAG_W-1:0]        query_tag1;
    logic [TAG_W-1:0]        query_tag2;
    logic                    query_ready1;
    logic                    query_ready2;
    logic [XLEN-1:0]         query_val1;
    logic [XLEN-1:0]         query_val2;
    logic [NUM_CDB-1:0]      cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0] cdb_val;
    logic                    commit_en;
    logic [4:0]              commit_rd;
    logic [XLEN-1:0]         commit_res;
    logic [TAG_W-1:0]        commit_lab;
    logic                    store_commit_en;
    logic                    rob2pred_en;
    logic                    pred_res;
    logic                    actual_taken;
    logic [XLEN-1:0]         rob2pre_curPC;
    logic                    flush_out;
    logic [XLEN-1:0]         newPC;

    modport master (
        output dec2rob_en, dec_is_branch, dec_is_store, dec_rd, dec_pc, dec_pred_taken, dec_target,
        output query_tag1, query_tag2, cdb_valid, cdb_tag, cdb_val,
        input  newTag, robFull, robEmpty, query_ready1, query_ready2, query_val1, query_val2,
        input  commit_en, commit_rd, commit_res, commit_lab, store_commit_en,
        input  rob2pred_en, pred_res, actual_taken, rob2pre_curPC, flush_out, newPC
    );

    modport slave (
        input  dec2rob_en, dec_is_branch, dec_is_store, dec_rd, dec_pc, dec_pred_taken, dec_target,
        input  query_tag1, query_tag2, cdb_valid, cdb_tag, cdb_val,
        output newTag, robFull, robEmpty, query_ready1, query_ready2, query_val1, query_val2,
        output commit_en, commit_rd, commit_res, commit_lab, store_commit_en,
        output rob2pred_en, pred_res, actual_taken, rob2pre_curPC, flush_out, newPC
    );

endinterface

// File: rtl/rob_cdb_merge.sv
// Folds NUM_CDB result buses into one write enable and value per ROB entry.
module rob_cdb_merge
    import rob_param_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32,
    parameter int TAG_W   = rob_tag_w(DEPTH)
) (
    input  logic [NUM_CDB-1:0]           cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag_i,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_val_i,
    output logic [DEPTH-1:0]             wr_en_o,
    output logic [DEPTH-1:0][XLEN-1:0]   wr_val_o
);

    logic hit_s;

    // Buses are scanned in ascending order so the highest-indexed bus wins a tag clash.
    always_comb begin
        wr_en_o  = '0;
        wr_val_o = '0;
        hit_s    = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int b = 0; b < NUM_CDB; b++) begin
                hit_s = cdb_valid_i[b]
                     && (cdb_tag_i[b*TAG_W +: TAG_W] != TAG_W'(ROB_TAG_NONE))
                     && (cdb_tag_i[b*TAG_W +: TAG_W] == TAG_W'(e + 1));
                wr_en_o[e]  = wr_en_o[e] | hit_s;
                wr_val_o[e] = hit_s ? cdb_val_i[b*XLEN +: XLEN] : wr_val_o[e];
            end
        end
    end

endmodule

// File: rtl/rob_param.sv
// Parametrised in-order-retire reorder buffer with branch resolution at commit.
// Optional same-cycle CDB forwarding to lookups and commit: define ROB_CDB_BYPASS_EN.
module rob_param
    import rob_param_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32
) (
    input logic         clk,
    input logic         rst_in,
    input logic         rdy_in,
    rob_param_if.slave  rob
);

    localparam int IDX_W = rob_idx_w(DEPTH);
    localparam int TAG_W = rob_tag_w(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    rob_ctrl_t              ctrl_q   [DEPTH];
    rob_ctrl_t              ctrl_d   [DEPTH];
    logic [XLEN-1:0]        pc_q     [DEPTH];
    logic [XLEN-1:0]        pc_d     [DEPTH];
    logic [XLEN-1:0]        target_q [DEPTH];
    logic [XLEN-1:0]        target_d [DEPTH];
    logic [XLEN-1:0]        res_q    [DEPTH];
    logic [XLEN-1:0]        res_d    [DEPTH];
    logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   commit_en_q, commit_en_d, store_commit_en_q, store_commit_en_d;
    logic                   rob2pred_en_q, rob2pred_en_d, flush_q, flush_d;
    logic                   pred_res_q, pred_res_d, actual_taken_q, actual_taken_d;
    logic [4:0]             commit_rd_q, commit_rd_d;
    logic [TAG_W-1:0]       commit_lab_q, commit_lab_d;
    logic [XLEN-1:0]        commit_res_q, commit_res_d, cur_pc_q, cur_pc_d, new_pc_q, new_pc_d;

    logic [DEPTH-1:0]             cdb_we_s, cdb_live_s;
    logic [DEPTH-1:0][XLEN-1:0]   cdb_wv_s;
    rob_ctrl_t                    head_ctrl_s;
    logic                         head_ready_s, issue_s, commit_s, mispredict_s;
    logic [XLEN-1:0]              head_res_s;
    logic [TAG_W-1:0]             qtag_s [2];
    logic                         qrdy_s [2];
    logic [XLEN-1:0]              qval_s [2];

    rob_cdb_merge #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN), .TAG_W(TAG_W)) u_cdb_merge (
        .cdb_valid_i (rob.cdb_valid),
        .cdb_tag_i   (rob.cdb_tag),
        .cdb_val_i   (rob.cdb_val),
        .wr_en_o     (cdb_we_s),
        .wr_val_o    (cdb_wv_s)
    );

    // A bus write only lands on a live entry while the core is enabled.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cdb_live_s[i] = cdb_we_s[i] & ctrl_q[i].valid & rdy_in;
        end
    end

    assign head_ctrl_s = ctrl_q[head_q];
`ifdef ROB_CDB_BYPASS_EN
    assign head_ready_s = head_ctrl_s.ready | cdb_live_s[head_q];
    assign head_res_s   = cdb_live_s[head_q] ? cdb_wv_s[head_q] : res_q[head_q];
`else
    assign head_ready_s = head_ctrl_s.ready;
    assign head_res_s   = res_q[head_q];
`endif
    assign issue_s      = rdy_in && rob.dec2rob_en && !rob.robFull && !flush_q;
    assign commit_s     = rdy_in && head_ctrl_s.valid && head_ready_s;
    assign mispredict_s = commit_s && head_ctrl_s.is_branch && (head_res_s[0] != head_ctrl_s.pred_taken);

    assign qtag_s[0] = rob.query_tag1;
    assign qtag_s[1] = rob.query_tag2;
    for (genvar q = 0; q < 2; q++) begin : g_query
        logic [IDX_W-1:0] idx_s;
        logic             hit_s;
        assign idx_s = IDX_W'(qtag_s[q] - TAG_W'(1));
        assign hit_s = (qtag_s[q] != TAG_W'(ROB_TAG_NONE)) && (qtag_s[q] <= TAG_W'(DEPTH)) && ctrl_q[idx_s].valid;
`ifdef ROB_CDB_BYPASS_EN
        assign qrdy_s[q] = hit_s && (ctrl_q[idx_s].ready || cdb_live_s[idx_s]);
        assign qval_s[q] = cdb_live_s[idx_s] ? cdb_wv_s[idx_s] : res_q[idx_s];
`else
        assign qrdy_s[q] = hit_s && ctrl_q[idx_s].ready;
        assign qval_s[q] = res_q[idx_s];
`endif
    end

    // Next state: result writes, issue at tail, retire at head, then a mispredict wipes everything.
    always_comb begin
        ctrl_d = ctrl_q;  pc_d = pc_q;  target_d = target_q;  res_d = res_q;
        head_d = head_q;  tail_d = tail_q;  count_d = count_q;
        commit_en_d = 1'b0;  store_commit_en_d = 1'b0;  rob2pred_en_d = 1'b0;  flush_d = 1'b0;
        commit_rd_d = commit_rd_q;  commit_res_d = commit_res_q;  commit_lab_d = commit_lab_q;
        pred_res_d = pred_res_q;  actual_taken_d = actual_taken_q;
        cur_pc_d = cur_pc_q;  new_pc_d = new_pc_q;
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_d[i].ready = ctrl_q[i].ready | cdb_live_s[i];
            res_d[i]        = cdb_live_s[i] ? cdb_wv_s[i] : res_q[i];
        end
        if (issue_s) begin
            ctrl_d[tail_q] = '{valid: 1'b1, ready: 1'b0, is_branch: rob.dec_is_branch,
                               is_store: rob.dec_is_store, rd: rob.dec_rd, pred_taken: rob.dec_pred_taken};
            pc_d[tail_q]     = rob.dec_pc;
            target_d[tail_q] = rob.dec_target;
            tail_d           = tail_q + IDX_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (commit_s) begin
            ctrl_d[head_q]    = '0;
            head_d            = head_q + IDX_W'(1);
            commit_en_d       = 1'b1;
            commit_rd_d       = head_ctrl_s.is_store ? 5'd0 : head_ctrl_s.rd;
            commit_res_d      = head_res_s;
            commit_lab_d      = TAG_W'(head_q) + TAG_W'(1);
            store_commit_en_d = head_ctrl_s.is_store;
            rob2pred_en_d     = head_ctrl_s.is_branch;
            if (head_ctrl_s.is_branch) begin
                actual_taken_d = head_res_s[0];
                pred_res_d     = !mispredict_s;
                cur_pc_d       = pc_q[head_q];
            end else begin
                actual_taken_d = actual_taken_q;
            end
            flush_d  = mispredict_s;
            new_pc_d = mispredict_s ? (head_res_s[0] ? target_q[head_q] : pc_q[head_q] + XLEN'(ROB_PC_INC))
                                    : new_pc_q;
        end else begin
            head_d = head_q;
        end
        if (mispredict_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            case ({issue_s, commit_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and output registers; rdy_in low is folded into the next-state logic above.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i]   <= '0;
                pc_q[i]     <= '0;
                target_q[i] <= '0;
                res_q[i]    <= '0;
            end
            head_q <= '0;  tail_q <= '0;  count_q <= '0;
            commit_en_q <= 1'b0;  store_commit_en_q <= 1'b0;  rob2pred_en_q <= 1'b0;  flush_q <= 1'b0;
            pred_res_q <= 1'b0;  actual_taken_q <= 1'b0;  commit_rd_q <= 5'd0;  commit_lab_q <= '0;
            commit_res_q <= '0;  cur_pc_q <= '0;  new_pc_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;  pc_q <= pc_d;  target_q <= target_d;  res_q <= res_d;
            head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
            commit_en_q <= commit_en_d;  store_commit_en_q <= store_commit_en_d;
            rob2pred_en_q <= rob2pred_en_d;  flush_q <= flush_d;
            pred_res_q <= pred_res_d;  actual_taken_q <= actual_taken_d;  commit_rd_q <= commit_rd_d;
            commit_lab_q <= commit_lab_d;  commit_res_q <= commit_res_d;
            cur_pc_q <= cur_pc_d;  new_pc_q <= new_pc_d;
        end
    end

    assign rob.newTag          = TAG_W'(tail_q) + TAG_W'(1);
    assign rob.robFull         = (count_q == CNT_W'(DEPTH));
    assign rob.robEmpty        = (count_q == CNT_W'(0));
    assign rob.query_ready1    = qrdy_s[0];
    assign rob.query_ready2    = qrdy_s[1];
    assign rob.query_val1      = qval_s[0];
    assign rob.query_val2      = qval_s[1];
    assign rob.commit_en       = commit_en_q;
    assign rob.commit_rd       = commit_rd_q;
    assign rob.commit_res      = commit_res_q;
    assign rob.commit_lab      = commit_lab_q;
    assign rob.store_commit_en = store_commit_en_q;
    assign rob.rob2pred_en     = rob2pred_en_q;
    assign rob.pred_res        = pred_res_q;
    assign rob.actual_taken    = actual_taken_q;
    assign rob.rob2pre_curPC   = cur_pc_q;
    assign rob.flush_out       = flush_q;
    assign rob.newPC           = new_pc_q;

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: queue-based reference model, directed scenarios, random traffic.
module tb_rob_param;

    localparam int DEPTH = 8, NUM_CDB = 2, XLEN = 32, TAG_W = 4;

    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    always #5 clk = ~clk;

    rob_param_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) rif ();
    rob_param #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) dut (
        .clk(clk), .rst_in(rst), .rdy_in(rdy), .rob(rif.slave));

    typedef struct { int tag; bit br; bit st; int rd; logic [31:0] pc; logic [31:0] tgt; bit pt; bit rdy; logic [31:0] res; } ent_t;
    typedef struct { int lab; logic [31:0] res; int cyc; } log_t;

    ent_t mq[$];
    log_t clog[$];
    int   next_tag, errors = 0, checks = 0, cyc = 0;
    bit   byp;
    bit   e_cen, e_sen, e_pen, e_flush, e_pres, e_act;
    int   e_rd, e_lab;
    logic [31:0] e_res, e_cpc, e_npc;
    bit   d_en, d_br, d_st, d_pt;
    int   d_rd;
    logic [31:0] d_pc, d_tgt;
    bit   cv [NUM_CDB];
    int   ct [NUM_CDB];
    logic [31:0] cd [NUM_CDB];
    int   q [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        next_tag = 1;
        {e_cen, e_sen, e_pen, e_flush, e_pres, e_act} = '0;
        e_rd = 0; e_lab = 0; e_res = '0; e_cpc = '0; e_npc = '0;
    endtask

    function automatic int find(input int tag);
        for (int i = 0; i < mq.size(); i++) if (mq[i].tag == tag) return i;
        return -1;
    endfunction

    // Same-cycle bus hit for forwarding: highest bus wins.
    function automatic bit cdb_hit(input int tag, output logic [31:0] v);
        bit h = 1'b0;
        v = '0;
        for (int b = 0; b < NUM_CDB; b++) if (rdy && cv[b] && ct[b] == tag) begin h = 1'b1; v = cd[b]; end
        return h;
    endfunction

    task automatic clear_drive();
        d_en = 0; d_br = 0; d_st = 0; d_pt = 0; d_rd = 0; d_pc = '0; d_tgt = '0;
        for (int b = 0; b < NUM_CDB; b++) begin cv[b] = 0; ct[b] = 0; cd[b] = '0; end
        q[0] = 0; q[1] = 0;
    endtask

    task automatic apply();
        rif.dec2rob_en = d_en; rif.dec_is_branch = d_br; rif.dec_is_store = d_st; rif.dec_rd = 5'(d_rd);
        rif.dec_pc = d_pc; rif.dec_pred_taken = d_pt; rif.dec_target = d_tgt;
        for (int b = 0; b < NUM_CDB; b++) begin
            rif.cdb_valid[b] = cv[b];
            rif.cdb_tag[b*TAG_W +: TAG_W] = TAG_W'(ct[b]);
            rif.cdb_val[b*XLEN +: XLEN] = cd[b];
        end
        rif.query_tag1 = TAG_W'(q[0]); rif.query_tag2 = TAG_W'(q[1]);
    endtask

    // One clock: drive, check lookups, advance the model, check registered outputs.
    task automatic tick();
        int idx; bit er, com, full, flush_prev, mis; logic [31:0] v, ev, cval; ent_t h;
        apply();
        #1;
        chk("newTag", rif.newTag, next_tag);
        chk("robFull", rif.robFull, mq.size() == DEPTH);
        chk("robEmpty", rif.robEmpty, mq.size() == 0);
        for (int k = 0; k < 2; k++) begin
            idx = find(q[k]);
            er = 0; ev = '0;
            if (idx >= 0) begin
                er = mq[idx].rdy; ev = mq[idx].res;
                if (byp && cdb_hit(q[k], v)) begin er = 1; ev = v; end
            end
            chk(k == 0 ? "query_ready1" : "query_ready2", k == 0 ? rif.query_ready1 : rif.query_ready2, er);
            if (er) chk(k == 0 ? "query_val1" : "query_val2", k == 0 ? rif.query_val1 : rif.query_val2, ev);
        end
        flush_prev = e_flush;
        e_cen = 0; e_sen = 0; e_pen = 0; e_flush = 0; mis = 0;
        if (rdy) begin
            full = (mq.size() == DEPTH);
            com = 0; cval = '0;
            if (mq.size() > 0) begin
                h = mq[0];
                if (h.rdy) begin com = 1; cval = h.res; end
                if (byp && cdb_hit(h.tag, v)) begin com = 1; cval = v; end
            end
            for (int b = 0; b < NUM_CDB; b++) if (cv[b]) begin
                idx = find(ct[b]);
                if (idx >= 0) begin mq[idx].rdy = 1; mq[idx].res = cd[b]; end
            end
            if (com) begin
                void'(mq.pop_front());
                e_cen = 1; e_lab = h.tag; e_res = cval; e_rd = h.st ? 0 : h.rd; e_sen = h.st;
                if (h.br) begin
                    e_pen = 1; e_act = cval[0]; e_pres = (cval[0] == h.pt); e_cpc = h.pc;
                    if (cval[0] != h.pt) begin mis = 1; e_flush = 1; e_npc = cval[0] ? h.tgt : h.pc + 32'd4; end
                end
            end
            if (d_en && !full && !flush_prev) begin
                mq.push_back('{tag: next_tag, br: d_br, st: d_st, rd: d_rd, pc: d_pc, tgt: d_tgt, pt: d_pt, rdy: 0, res: '0});
                next_tag = next_tag % DEPTH + 1;
            end
            if (mis) begin mq.delete(); next_tag = 1; end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("commit_en", rif.commit_en, e_cen);
        chk("store_commit_en", rif.store_commit_en, e_sen);
        chk("rob2pred_en", rif.rob2pred_en, e_pen);
        chk("flush_out", rif.flush_out, e_flush);
        chk("commit_rd", rif.commit_rd, e_rd);
        chk("commit_res", rif.commit_res, e_res);
        chk("commit_lab", rif.commit_lab, e_lab);
        chk("pred_res", rif.pred_res, e_pres);
        chk("actual_taken", rif.actual_taken, e_act);
        chk("rob2pre_curPC", rif.rob2pre_curPC, e_cpc);
        chk("newPC", rif.newPC, e_npc);
        if (rif.commit_en) clog.push_back('{lab: int'(rif.commit_lab), res: rif.commit_res, cyc: cyc});
        clear_drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard, n;
        guard = 0;
        while (mq.size() > 0 && guard < 100) begin
            n = 0;
            for (int i = 0; i < mq.size() && n < NUM_CDB; i++) if (!mq[i].rdy) begin
                cv[n] = 1; ct[n] = mq[i].tag; cd[n] = $urandom; n++;
            end
            tick();
            guard++;
        end
        chk("drain_done", mq.size(), 0);
    endtask

    task automatic rand_drive();
        rdy = ($urandom_range(0, 9) != 0);
        d_en = ($urandom_range(0, 9) < 6);
        d_br = ($urandom_range(0, 4) == 0);
        d_st = !d_br && ($urandom_range(0, 4) == 0);
        d_rd = $urandom_range(0, 31); d_pt = $urandom_range(0, 1);
        d_pc = $urandom & 32'hFFFF_FFFC; d_tgt = $urandom & 32'hFFFF_FFFC;
        for (int b = 0; b < NUM_CDB; b++) begin
            cv[b] = ($urandom_range(0, 2) != 0);
            if (mq.size() > 0 && $urandom_range(0, 7) != 0) ct[b] = mq[$urandom_range(0, mq.size() - 1)].tag;
            else ct[b] = $urandom_range(0, 15);
            cd[b] = $urandom;
        end
        for (int k = 0; k < 2; k++) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) q[k] = mq[$urandom_range(0, mq.size() - 1)].tag;
            else q[k] = $urandom_range(0, 15);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ROB_CDB_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        clear_drive();
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_robEmpty", rif.robEmpty, 1);
        chk("rst_robFull", rif.robFull, 0);
        chk("rst_newTag", rif.newTag, 1);
        chk("rst_commit_en", rif.commit_en, 0);
        chk("rst_flush_out", rif.flush_out, 0);
        chk("rst_newPC", rif.newPC, 0);
        rst = 1'b0;

        // Fill to full, a blocked 9th issue, then commit while full with an issue pending.
        for (int i = 0; i < DEPTH; i++) begin d_en = 1; d_rd = i + 1; d_pc = 32'h1000 + 32'(4 * i); tick(); end
        chk("s1_full", rif.robFull, 1);
        chk("s1_tag_wrap", rif.newTag, 1);
        d_en = 1; d_rd = 9; tick();
        chk("s1_ignored_full", rif.robFull, 1);
        chk("s1_ignored_tag", rif.newTag, 1);
        cv[0] = 1; ct[0] = 1; cd[0] = 32'hAA; d_en = 1; d_rd = 9; tick();
        d_en = 1; d_rd = 9; tick();
        chk("s1_commit_frees", rif.robFull, 0);
        d_en = 1; d_rd = 9; tick();
        chk("s1_refull", rif.robFull, 1);
        drain();

        // Out-of-order results retire in order on consecutive cycles.
        do_reset();
        for (int i = 0; i < 3; i++) begin d_en = 1; d_rd = i + 1; tick(); end
        clog.delete();
        cv[0] = 1; ct[0] = 3; cd[0] = 32'd7; tick();
        cv[0] = 1; ct[0] = 1; cd[0] = 32'd5; tick();
        cv[1] = 1; ct[1] = 2; cd[1] = 32'd6; tick();
        repeat (3) tick();
        chk("s2_commits", clog.size(), 3);
        for (int i = 0; i < clog.size(); i++) begin
            chk("s2_lab", clog[i].lab, i + 1);
            chk("s2_res", clog[i].res, 32'(i + 5));
            if (i > 0) chk("s2_consecutive", clog[i].cyc, clog[i-1].cyc + 1);
        end

        // Two buses in one cycle, then lookup.
        do_reset();
        for (int i = 0; i < 4; i++) begin d_en = 1; d_rd = i + 1; tick(); end
        cv[0] = 1; ct[0] = 2; cd[0] = 32'd9; cv[1] = 1; ct[1] = 4; cd[1] = 32'd11; tick();
        q[0] = 2; q[1] = 4; tick();
        q[0] = 2; q[1] = 4; apply(); #1;
        chk("s3_ready1", rif.query_ready1, 1);
        chk("s3_ready2", rif.query_ready2, 1);
        chk("s3_val1", rif.query_val1, 32'd9);
        chk("s3_val2", rif.query_val2, 32'd11);
        clear_drive(); apply();
        @(posedge clk); #1;
        drain();

        // Mispredicted branch: predicted taken, resolved not taken.
        do_reset();
        d_en = 1; d_br = 1; d_pc = 32'h100; d_pt = 1; d_tgt = 32'h200; tick();
        cv[0] = 1; ct[0] = 1; cd[0] = 32'd0; tick();
        tick();
        chk("s4_flush", rif.flush_out, 1);
        chk("s4_newPC", rif.newPC, 32'h104);
        chk("s4_pred_res", rif.pred_res, 0);
        tick();
        chk("s4_empty", rif.robEmpty, 1);
        chk("s4_newTag", rif.newTag, 1);

        // Store retire.
        do_reset();
        d_en = 1; d_st = 1; d_rd = 5; tick();
        cv[0] = 1; ct[0] = 1; cd[0] = 32'h55; tick();
        tick();
        chk("s5_store_en", rif.store_commit_en, 1);
        chk("s5_store_rd", rif.commit_rd, 0);

        // Reset while five entries are pending and the head is about to retire.
        do_reset();
        for (int i = 0; i < 5; i++) begin d_en = 1; d_rd = i + 1; tick(); end
        cv[0] = 1; ct[0] = 1; cd[0] = 32'h1234; tick();
        #2; rst = 1'b1; #1;
        chk("s6_empty", rif.robEmpty, 1);
        chk("s6_newTag", rif.newTag, 1);
        chk("s6_no_commit", rif.commit_en, 0);
        model_reset();
        @(posedge clk); #1;
        chk("s6_no_commit_edge", rif.commit_en, 0);
        chk("s6_no_flush", rif.flush_out, 0);
        rst = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin rand_drive(); tick(); end
        rdy = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
